lc3b_evict_buffer: RTL and testbench

Parametrised write-back eviction buffer between the L1 data cache and L2 (or physical memory). Dirty lines evicted by L1 are queued in FIFO order and drained to the lower level with a mem_write/mem_resp handshake, so L1 can service its refill without waiting for the writeback. L1 miss addresses are looked up in the buffer, and a hit forwards the buffered line combinationally. Generalises the fixed 128-bit line / 16-bit address cache types to any line width, address width and depth.

---
 rtl/lc3b_evict_buffer_pkg.sv | 19 +
 rtl/lc3b_evict_buffer_if.sv | 32 +++
 rtl/lc3b_evict_buffer_match.sv | 42 ++++
 rtl/lc3b_evict_buffer.sv | 190 +++++++++++++++++++
 tb/tb_lc3b_evict_buffer.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lc3b_evict_buffer_pkg.sv
// Shared types and defaults for the LC-3b write-back eviction buffer.
// Optional feature macro: LC3B_EVICT_COALESCE_EN (see lc3b_evict_buffer.sv).
package lc3b_evict_buffer_pkg;

  localparam int LC3B_C_ADDR_W    = 16;
  localparam int LC3B_C_LINE_W    = 128;
  localparam int LC3B_C_EVB_DEPTH = 4;

  typedef enum logic [0:0] {
    evb_idle  = 1'b0,
    evb_write = 1'b1
  } lc3b_evb_state;

  // Byte-offset bits inside a line of line_w bits.
  function automatic int lc3b_line_off_w(input int line_w);
    return $clog2(line_w / 8);
  endfunction

endpackage

// File: rtl/lc3b_evict_buffer_if.sv
// Bus bundle between L1 (push/lookup), the eviction buffer and the lower memory level.
// Handshakes: a push transfers on a clock edge where push_valid && push_ready are both high;
// mem_write is held with stable address/data until the edge where mem_resp is high.
interface lc3b_evict_buffer_if #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
);

  logic              push_valid;
  logic              push_ready;
  logic [ADDR_W-1:0] push_addr;
  logic [LINE_W-1:0] push_data;
  logic [ADDR_W-1:0] lookup_addr;
  logic              lookup_hit;
  logic [LINE_W-1:0] lookup_data;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_resp;
  logic              empty;

  modport slave (
    input  push_valid, push_addr, push_data, lookup_addr, mem_resp,
    output push_ready, lookup_hit, lookup_data, mem_write, mem_address, mem_wdata, empty
  );

  modport master (
    output push_valid, push_addr, push_data, lookup_addr, mem_resp,
    input  push_ready, lookup_hit, lookup_data, mem_write, mem_address, mem_wdata, empty
  );

endinterface

// File: rtl/lc3b_evict_buffer_match.sv
// Parallel tag compare over all buffer entries; among several matches the youngest
// (furthest from head in circular order) is reported.
module lc3b_evict_buffer_match
  import lc3b_evict_buffer_pkg::*;
#(
  parameter int DEPTH = LC3B_C_EVB_DEPTH,
  parameter int TAG_W = 12,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]            valid,
  input  logic [DEPTH-1:0]            mask,
  input  logic [DEPTH-1:0][TAG_W-1:0] tags,
  input  logic [TAG_W-1:0]            key,
  input  logic [PTR_W-1:0]            head,
  output logic                        hit,
  output logic [PTR_W-1:0]            idx,
  output logic [DEPTH-1:0]            match_vec
);

  logic [PTR_W-1:0] pos;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      match_vec[i] = valid[i] && !mask[i] && (tags[i] == key);
    end
  end

  // Walk from head towards tail so the last hit seen is the youngest one.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    pos = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pos = head + PTR_W'(k);
      if (match_vec[pos]) begin
        hit = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/lc3b_evict_buffer.sv
// FIFO write-back eviction buffer: queues dirty L1 lines, drains them with mem_write/mem_resp,
// and forwards buffered lines to L1 misses. Define LC3B_EVICT_COALESCE_EN to merge repeat pushes.
module lc3b_evict_buffer
  import lc3b_evict_buffer_pkg::*;
#(
  parameter int ADDR_W = LC3B_C_ADDR_W,
  parameter int LINE_W = LC3B_C_LINE_W,
  parameter int DEPTH  = LC3B_C_EVB_DEPTH,
  localparam int OFF_W = lc3b_line_off_w(LINE_W),
  localparam int TAG_W = ADDR_W - OFF_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  lc3b_evict_buffer_if.slave   bus,
  output lc3b_evb_state        dbg_state,
  output logic [CNT_W-1:0]     dbg_count,
  output logic [PTR_W-1:0]     dbg_head,
  output logic [PTR_W-1:0]     dbg_tail,
  output logic [DEPTH-1:0]     dbg_lookup_vec,
  output logic [DEPTH-1:0]     dbg_coalesce_vec
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  lc3b_evb_state state_q, state_d;

  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [LINE_W-1:0]           data_q [DEPTH];
  logic [LINE_W-1:0]           data_d [DEPTH];
  logic [PTR_W-1:0]            head_q, head_d;
  logic [PTR_W-1:0]            tail_q, tail_d;
  logic [CNT_W-1:0]            count_q, count_d;

  logic [TAG_W-1:0] push_tag;
  logic [TAG_W-1:0] lookup_tag;
  logic [DEPTH-1:0] inflight_vec;
  logic             lk_hit;
  logic [PTR_W-1:0] lk_idx;
  logic [DEPTH-1:0] lk_vec;
  logic             co_hit;
  logic [PTR_W-1:0] co_idx;
  logic [DEPTH-1:0] co_vec;
  logic             push_fire;
  logic             alloc;
  logic             pop;

  assign push_tag   = bus.push_addr[ADDR_W-1:OFF_W];
  assign lookup_tag = bus.lookup_addr[ADDR_W-1:OFF_W];

  // The head entry is owned by the lower level while a write is outstanding.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      inflight_vec[i] = (state_q == evb_write) && (head_q == PTR_W'(i));
    end
  end

  lc3b_evict_buffer_match #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_lookup_match (
    .valid     (valid_q),
    .mask      ('0),
    .tags      (tag_q),
    .key       (lookup_tag),
    .head      (head_q),
    .hit       (lk_hit),
    .idx       (lk_idx),
    .match_vec (lk_vec)
  );

`ifdef LC3B_EVICT_COALESCE_EN
  lc3b_evict_buffer_match #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_coalesce_match (
    .valid     (valid_q),
    .mask      (inflight_vec),
    .tags      (tag_q),
    .key       (push_tag),
    .head      (head_q),
    .hit       (co_hit),
    .idx       (co_idx),
    .match_vec (co_vec)
  );
`else
  assign co_hit = 1'b0;
  assign co_idx = '0;
  assign co_vec = inflight_vec & '0;
`endif

  // Ready depends only on current state: a same-cycle pop never frees a slot for a push.
  assign bus.push_ready = (count_q < CNT_MAX) || co_hit;
  assign push_fire      = bus.push_valid && bus.push_ready;
  assign alloc          = push_fire && !co_hit;
  assign pop            = (state_q == evb_write) && bus.mem_resp;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= evb_idle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      evb_idle:  if (count_q != '0) state_d = evb_write;
      evb_write: if (bus.mem_resp)  state_d = evb_idle;
    endcase
  end

  // FSM outputs: address and data are only presented while a write is outstanding.
  always_comb begin
    bus.mem_write   = 1'b0;
    bus.mem_address = '0;
    bus.mem_wdata   = '0;
    if (state_q == evb_write) begin
      bus.mem_write   = 1'b1;
      bus.mem_address = {tag_q[head_q], {OFF_W{1'b0}}};
      bus.mem_wdata   = data_q[head_q];
    end
  end

  always_comb begin
    bus.lookup_hit  = lk_hit;
    bus.lookup_data = lk_hit ? data_q[lk_idx] : '0;
    bus.empty       = (count_q == '0);
  end

  // Entry storage and pointer update
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_ONE;
    end
    if (push_fire) begin
      if (co_hit) begin
        data_d[co_idx] = bus.push_data;
      end else begin
        valid_d[tail_q] = 1'b1;
        tag_d[tail_q]   = push_tag;
        data_d[tail_q]  = bus.push_data;
        tail_d          = tail_q + PTR_ONE;
      end
    end
    count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      tag_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign dbg_state        = state_q;
  assign dbg_count        = count_q;
  assign dbg_head         = head_q;
  assign dbg_tail         = tail_q;
  assign dbg_lookup_vec   = lk_vec;
  assign dbg_coalesce_vec = co_vec;

endmodule

// File: tb/tb_lc3b_evict_buffer.sv
// Directed bench for lc3b_evict_buffer (DEPTH=4, LINE_W=128, ADDR_W=16); expectations for the
// LC3B_EVICT_COALESCE_EN build are selected with the same macro.
module tb_lc3b_evict_buffer;
  import lc3b_evict_buffer_pkg::*;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;
  localparam int DEPTH  = 4;

  logic clk;
  logic rst;
  lc3b_evb_state dbg_state;
  logic [2:0]    dbg_count;
  logic [1:0]    dbg_head;
  logic [1:0]    dbg_tail;
  logic [3:0]    dbg_lookup_vec;
  logic [3:0]    dbg_coalesce_vec;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [LINE_W-1:0] exp_q[$];

  lc3b_evict_buffer_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  lc3b_evict_buffer #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .dbg_state        (dbg_state),
    .dbg_count        (dbg_count),
    .dbg_head         (dbg_head),
    .dbg_tail         (dbg_tail),
    .dbg_lookup_vec   (dbg_lookup_vec),
    .dbg_coalesce_vec (dbg_coalesce_vec)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
    int w;
    bus.push_valid = 1'b1;
    bus.push_addr  = a;
    bus.push_data  = d;
    #1;
    w = 0;
    while (bus.push_ready !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    if (bus.push_ready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL push_ready_timeout: addr %h never accepted", a);
    end
    tick();
    bus.push_valid = 1'b0;
  endtask

  // scoreboard: drains the buffer, matching every write against exp_addr_q/exp_q in order
  task automatic drain_all(input string name);
    int w;
    logic [ADDR_W-1:0] ea;
    logic [LINE_W-1:0] ed;
    while (exp_q.size() > 0) begin
      w = 0;
      while (bus.mem_write !== 1'b1 && w < 20) begin
        tick();
        w++;
      end
      n_checks++;
      if (bus.mem_write !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_write_timeout: got mem_write=%b required 1 (%0d writes missing)", name, bus.mem_write, exp_q.size());
        exp_q.delete();
        exp_addr_q.delete();
      end else begin
        ea = exp_addr_q.pop_front();
        ed = exp_q.pop_front();
        n_checks++; if (bus.mem_address !== ea) begin n_fail++; $display("FAIL %s_addr: got %h required %h", name, bus.mem_address, ea); end
        n_checks++; if (bus.mem_wdata !== ed) begin n_fail++; $display("FAIL %s_data: got %h required %h", name, bus.mem_wdata, ed); end
        bus.mem_resp = 1'b1;
        tick();
        bus.mem_resp = 1'b0;
        #1;
        n_checks++; if (bus.mem_write !== 1'b0) begin n_fail++; $display("FAIL %s_gap: got mem_write=%b required 0 after resp", name, bus.mem_write); end
      end
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (bus.mem_write !== 1'b0) begin n_fail++; $display("FAIL %s_extra_write: got mem_write=1 addr %h required no write", name, bus.mem_address); end
    end
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL %s_empty_after: got %b required 1", name, bus.empty); end
  endtask

  // scenarios
  task automatic test_reset();
    n_checks++; if (bus.push_ready !== 1'b1) begin n_fail++; $display("FAIL reset_push_ready: got %b required 1", bus.push_ready); end
    n_checks++; if (bus.mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_mem_write: got %b required 0", bus.mem_write); end
    n_checks++; if (bus.mem_address !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_address: got %h required 0000", bus.mem_address); end
    n_checks++; if (bus.mem_wdata !== '0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h required 0", bus.mem_wdata); end
    n_checks++; if (bus.lookup_hit !== 1'b0) begin n_fail++; $display("FAIL reset_lookup_hit: got %b required 0", bus.lookup_hit); end
    n_checks++; if (bus.lookup_data !== '0) begin n_fail++; $display("FAIL reset_lookup_data: got %h required 0", bus.lookup_data); end
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b required 1", bus.empty); end
  endtask

  task automatic test_single();
    logic [LINE_W-1:0] d1;
    d1 = {4{32'hD1D1_0001}};
    do_push(16'h1230, d1);
    bus.lookup_addr = 16'h123F;
    #1;
    n_checks++; if (bus.empty !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %b required 0", bus.empty); end
    n_checks++; if (bus.lookup_hit !== 1'b1) begin n_fail++; $display("FAIL single_lookup_hit: got %b required 1", bus.lookup_hit); end
    n_checks++; if (bus.lookup_data !== d1) begin n_fail++; $display("FAIL single_lookup_data: got %h required %h", bus.lookup_data, d1); end
    n_checks++; if (bus.mem_write !== 1'b0) begin n_fail++; $display("FAIL single_write_early: got %b required 0", bus.mem_write); end
    tick();
    n_checks++; if (bus.mem_write !== 1'b1) begin n_fail++; $display("FAIL single_write_latency: got %b required 1", bus.mem_write); end
    n_checks++; if (bus.mem_address !== 16'h1230) begin n_fail++; $display("FAIL single_mem_address: got %h required 1230", bus.mem_address); end
    n_checks++; if (bus.mem_wdata !== d1) begin n_fail++; $display("FAIL single_mem_wdata: got %h required %h", bus.mem_wdata, d1); end
    bus.mem_resp = 1'b1;
    tick();
    bus.mem_resp = 1'b0;
    #1;
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL single_empty_after: got %b required 1", bus.empty); end
    n_checks++; if (bus.lookup_hit !== 1'b0) begin n_fail++; $display("FAIL single_lookup_miss: got %b required 0", bus.lookup_hit); end
    n_checks++; if (bus.mem_write !== 1'b0) begin n_fail++; $display("FAIL single_mem_write_after: got %b required 0", bus.mem_write); end
    // mem_resp while idle must not disturb anything
    bus.mem_resp = 1'b1;
    tick();
    bus.mem_resp = 1'b0;
    n_checks++; if (dbg_count !== 3'd0) begin n_fail++; $display("FAIL idle_resp_count: got %0d required 0", dbg_count); end
  endtask

  task automatic test_full();
    logic [LINE_W-1:0] e [5];
    for (int i = 0; i < 5; i++) e[i] = {4{32'hE000_0000 + 32'(i)}};
    for (int i = 0; i < 4; i++) do_push(16'h4000 + 16'(i * 16), e[i]);
    bus.push_valid = 1'b1;
    bus.push_addr  = 16'h4040;
    bus.push_data  = e[4];
    bus.mem_resp   = 1'b1;
    #1;
    n_checks++; if (bus.push_ready !== 1'b0) begin n_fail++; $display("FAIL full_push_ready: got %b required 0", bus.push_ready); end
    n_checks++; if (bus.mem_address !== 16'h4000) begin n_fail++; $display("FAIL full_head_addr: got %h required 4000", bus.mem_address); end
    n_checks++; if (bus.mem_wdata !== e[0]) begin n_fail++; $display("FAIL full_head_data: got %h required %h", bus.mem_wdata, e[0]); end
    tick();
    bus.mem_resp = 1'b0;
    #1;
    n_checks++; if (dbg_count !== 3'd3) begin n_fail++; $display("FAIL full_no_passthrough: got count %0d required 3", dbg_count); end
    n_checks++; if (bus.push_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after_pop: got %b required 1", bus.push_ready); end
    tick();
    bus.push_valid = 1'b0;
    #1;
    n_checks++; if (dbg_count !== 3'd4) begin n_fail++; $display("FAIL full_late_push: got count %0d required 4", dbg_count); end
    for (int i = 1; i < 5; i++) begin
      exp_addr_q.push_back(16'h4000 + 16'(i * 16));
      exp_q.push_back(e[i]);
    end
    drain_all("full");
  endtask

  task automatic test_inflight();
    logic [LINE_W-1:0] d1, d2, d3, d4;
    d1 = {4{32'h2000_00D1}};
    d2 = {4{32'h3000_00D2}};
    d3 = {4{32'h3000_00D3}};
    d4 = {4{32'h2000_00D4}};
    do_push(16'h2000, d1);
    do_push(16'h3000, d2);
    n_checks++; if (bus.mem_address !== 16'h2000 || bus.mem_write !== 1'b1) begin n_fail++; $display("FAIL inflight_head: got write=%b addr %h required 1/2000", bus.mem_write, bus.mem_address); end
    do_push(16'h3000, d3);
`ifdef LC3B_EVICT_COALESCE_EN
    n_checks++; if (dbg_count !== 3'd2) begin n_fail++; $display("FAIL coalesce_count: got %0d required 2", dbg_count); end
`else
    n_checks++; if (dbg_count !== 3'd3) begin n_fail++; $display("FAIL dup_alloc_count: got %0d required 3", dbg_count); end
`endif
    bus.lookup_addr = 16'h3004;
    #1;
    n_checks++; if (bus.lookup_data !== d3) begin n_fail++; $display("FAIL youngest_3000: got %h required %h", bus.lookup_data, d3); end
    do_push(16'h2000, d4);
    bus.lookup_addr = 16'h2000;
    #1;
    n_checks++; if (bus.lookup_data !== d4) begin n_fail++; $display("FAIL youngest_2000: got %h required %h", bus.lookup_data, d4); end
    n_checks++; if (bus.mem_wdata !== d1) begin n_fail++; $display("FAIL inflight_held: got %h required %h", bus.mem_wdata, d1); end
    exp_addr_q.push_back(16'h2000); exp_q.push_back(d1);
`ifndef LC3B_EVICT_COALESCE_EN
    exp_addr_q.push_back(16'h3000); exp_q.push_back(d2);
`endif
    exp_addr_q.push_back(16'h3000); exp_q.push_back(d3);
    exp_addr_q.push_back(16'h2000); exp_q.push_back(d4);
    drain_all("inflight");
  endtask

  task automatic test_reset_mid_write();
    int writes;
    for (int i = 0; i < 3; i++) do_push(16'h5000 + 16'(i * 16), {4{32'h5000_0000 + 32'(i)}});
    n_checks++; if (bus.mem_write !== 1'b1) begin n_fail++; $display("FAIL rstw_pre_write: got %b required 1", bus.mem_write); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.mem_write !== 1'b0) begin n_fail++; $display("FAIL rstw_mem_write: got %b required 0", bus.mem_write); end
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL rstw_empty: got %b required 1", bus.empty); end
    n_checks++; if (bus.mem_address !== 16'h0000) begin n_fail++; $display("FAIL rstw_mem_address: got %h required 0000", bus.mem_address); end
    tick();
    tick();
    rst = 1'b0;
    writes = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.mem_write === 1'b1) writes++;
    end
    n_checks++; if (writes != 0) begin n_fail++; $display("FAIL rstw_stale_writes: got %0d write cycles required 0", writes); end
  endtask

  task automatic test_wrap();
    logic [LINE_W-1:0] d;
    for (int i = 0; i < 2 * DEPTH + 1; i++) begin
      d = {4{32'hC0DE_0000 + 32'(i)}};
      do_push(16'h6000 + 16'(i * 16), d);
      exp_addr_q.push_back(16'h6000 + 16'(i * 16));
      exp_q.push_back(d);
      drain_all("wrap");
    end
    n_checks++; if (dbg_head !== 2'd1 || dbg_tail !== 2'd1) begin n_fail++; $display("FAIL wrap_pointers: got head %0d tail %0d required 1/1", dbg_head, dbg_tail); end
  endtask

  task automatic test_back_to_back();
    logic [LINE_W-1:0] d;
    for (int i = 0; i < 3; i++) begin
      d = {4{32'hB2B0_0000 + 32'(i)}};
      do_push(16'h7000 + 16'(i * 32), d);
      exp_addr_q.push_back(16'h7000 + 16'(i * 32));
      exp_q.push_back(d);
    end
    drain_all("b2b");
  endtask

  initial begin
    rst              = 1'b1;
    bus.push_valid   = 1'b0;
    bus.push_addr    = '0;
    bus.push_data    = '0;
    bus.lookup_addr  = '0;
    bus.mem_resp     = 1'b0;
    #1;
    test_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_single();
    test_full();
    test_inflight();
    test_reset_mid_write();
    test_wrap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
